// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the cache sequencing FSM.
// Direct-mapped, 2048 lines, one 32-bit word per line.
package cache_ctrl_pkg;

    localparam int CACHE_LINES   = 2048;
    localparam int CACHE_TAG_W   = 3;
    localparam int CACHE_INDEX_W = 11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } cache_ctrl_state_t;

endpackage

// File: rtl/cache_stat_counters.sv
// Hit / miss / write-back event counters, all 32-bit wrapping.
// Instantiated by cache_controller only when CACHE_CTRL_STATS_EN is defined.
module cache_stat_counters (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready_ev,
    input  logic        miss_ev,
    input  logic        wb_ev,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_writebacks
);

    logic missed;

    // Count events; a completion after a miss is the retry, not a hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            missed          <= 1'b0;
            stat_hits       <= '0;
            stat_misses     <= '0;
            stat_writebacks <= '0;
        end else begin
            if (miss_ev) begin
                missed <= 1'b1;
            end else if (ready_ev) begin
                missed <= 1'b0;
            end
            if (ready_ev && !missed) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (miss_ev) begin
                stat_misses <= stat_misses + 32'd1;
            end
            if (wb_ev) begin
                stat_writebacks <= stat_writebacks + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Hit / clean-miss / dirty-miss sequencer between CPU, cache array and memory.
// Optional statistics outputs enabled by defining CACHE_CTRL_STATS_EN.
module cache_controller
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_is_word,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    input  logic              cache_hit,
    input  logic              cache_dirty,
    input  logic [DATA_W-1:0] cache_rdata,
    input  logic [ADDR_W-1:0] cache_wb_addr,
    output logic [ADDR_W-1:0] cache_addr,
    output logic              cache_we,
    output logic              cache_is_word,
    output logic [DATA_W-1:0] cache_wdata,
    output logic              cache_meta_we,
    output logic              cache_set_valid,
    output logic              cache_set_dirty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_CTRL_STATS_EN
   ,output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses,
    output logic [31:0]       stat_writebacks
`endif
);

    cache_ctrl_state_t state_q, state_d;

    assign cache_addr = cpu_addr;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and strobes; reset masks everything, including a late ack.
    always_comb begin
        state_d         = state_q;
        cpu_ready       = 1'b0;
        cache_we        = 1'b0;
        cache_is_word   = 1'b0;
        cache_wdata     = '0;
        cache_meta_we   = 1'b0;
        cache_set_valid = 1'b0;
        cache_set_dirty = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        if (reset) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        if (cache_hit) begin
                            cpu_ready = 1'b1;
                            if (cpu_we) begin
                                cache_we        = 1'b1;
                                cache_is_word   = cpu_is_word;
                                cache_wdata     = cpu_wdata;
                                cache_meta_we   = 1'b1;
                                cache_set_valid = 1'b1;
                                cache_set_dirty = 1'b1;
                            end
                        end else if (cache_dirty) begin
                            state_d = WRITEBACK;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = cache_wb_addr;
                    mem_wdata = cache_rdata;
                    if (mem_ack) begin
                        state_d = FILL;
                    end
                end
                FILL: begin
                    mem_req  = 1'b1;
                    mem_addr = {cpu_addr[ADDR_W-1:2], 2'b00};
                    if (mem_ack) begin
                        cache_we        = 1'b1;
                        cache_is_word   = 1'b1;
                        cache_wdata     = mem_rdata;
                        cache_meta_we   = 1'b1;
                        cache_set_valid = 1'b1;
                        state_d         = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

`ifdef CACHE_CTRL_STATS_EN
    logic miss_ev;
    logic wb_ev;

    assign miss_ev = (state_q == IDLE) && (state_d != IDLE);
    assign wb_ev   = (state_q == WRITEBACK) && (state_d == FILL);

    cache_stat_counters u_stats (
        .clk             (clk),
        .reset           (reset),
        .ready_ev        (cpu_ready),
        .miss_ev         (miss_ev),
        .wb_ev           (wb_ev),
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
    );
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array,
// a delayed-ack memory and scoreboards for CPU completions and memory traffic.
module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_is_word;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cache_hit;
    logic        cache_dirty;
    logic [31:0] cache_rdata;
    logic [31:0] cache_wb_addr;
    logic [31:0] cache_addr;
    logic        cache_we;
    logic        cache_is_word;
    logic [31:0] cache_wdata;
    logic        cache_meta_we;
    logic        cache_set_valid;
    logic        cache_set_dirty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
    logic [31:0] stat_writebacks;
`endif

    cache_controller dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_req         (cpu_req),
        .cpu_we          (cpu_we),
        .cpu_is_word     (cpu_is_word),
        .cpu_addr        (cpu_addr),
        .cpu_wdata       (cpu_wdata),
        .cpu_ready       (cpu_ready),
        .cache_hit       (cache_hit),
        .cache_dirty     (cache_dirty),
        .cache_rdata     (cache_rdata),
        .cache_wb_addr   (cache_wb_addr),
        .cache_addr      (cache_addr),
        .cache_we        (cache_we),
        .cache_is_word   (cache_is_word),
        .cache_wdata     (cache_wdata),
        .cache_meta_we   (cache_meta_we),
        .cache_set_valid (cache_set_valid),
        .cache_set_dirty (cache_set_dirty),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
       ,.stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural cache array: index addr[12:2], tag addr[15:13].
    logic        c_valid [0:2047];
    logic        c_dirty [0:2047];
    logic [2:0]  c_tag   [0:2047];
    logic [31:0] c_data  [0:2047];
    logic [10:0] idx;

    assign idx           = cache_addr[12:2];
    assign cache_hit     = c_valid[idx] && (c_tag[idx] == cache_addr[15:13]);
    assign cache_dirty   = c_valid[idx] && c_dirty[idx];
    assign cache_rdata   = c_data[idx];
    assign cache_wb_addr = {16'h0, c_tag[idx], idx, 2'b00};

    always @(posedge clk) begin
        if (cache_we) begin
            c_tag[idx] <= cache_addr[15:13];
            if (cache_is_word) begin
                c_data[idx] <= cache_wdata;
            end else begin
                c_data[idx][8*cache_addr[1:0] +: 8] <= cache_wdata[7:0];
            end
        end
        if (cache_meta_we) begin
            c_valid[idx] <= cache_set_valid;
            c_dirty[idx] <= cache_set_dirty;
        end
    end

    // Backing memory with a scoreboard of expected transactions.
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mtx_t;

    mtx_t        exp_mq [$];
    logic [31:0] mem_arr [logic [31:0]];
    logic        mem_auto;
    int          mem_delay;

    initial begin
        int   cnt;
        mtx_t m;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                cnt = 0;
            end else begin
                if (mem_ack) begin
                    mem_ack = 1'b0;
                    cnt     = 0;
                end
                if (mem_req) begin
                    cnt++;
                    if (cnt > mem_delay) begin
                        mem_ack = 1'b1;
                        if (exp_mq.size() == 0) begin
                            chk("mem_unexpected", 32'd1, 32'd0);
                        end else begin
                            m = exp_mq.pop_front();
                            chk("mem_we", {31'b0, mem_we}, {31'b0, m.we});
                            chk("mem_addr", mem_addr, m.addr);
                            if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                        end
                        if (mem_we) begin
                            mem_arr[mem_addr] = mem_wdata;
                        end else if (mem_arr.exists(mem_addr)) begin
                            mem_rdata = mem_arr[mem_addr];
                        end else begin
                            mem_rdata = 32'h0;
                        end
                    end
                end
            end
        end
    end

    // CPU completion scoreboard.
    typedef struct {
        logic        we;
        logic        is_word;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } ctx_t;

    ctx_t exp_cq [$];

    task automatic access(input logic [31:0] a, input logic w,
                          input logic iw, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input int exp_lat,
                          input string tag);
        ctx_t e;
        int   lat;
        bit   done;
        exp_cq.push_back('{w, iw, wd, exp_rd, exp_lat});
        @(posedge clk);
        #1;
        cpu_req     = 1'b1;
        cpu_addr    = a;
        cpu_we      = w;
        cpu_is_word = iw;
        cpu_wdata   = wd;
        lat  = 0;
        done = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            if (cpu_ready) begin
                done = 1;
                e = exp_cq.pop_front();
                chk({tag, "_lat"}, lat, e.lat);
                if (e.lat == 0) chk({tag, "_hit_nomem"}, {31'b0, mem_req}, 32'd0);
                if (!e.we) begin
                    chk({tag, "_rdata"}, cache_rdata, e.rdata);
                    chk({tag, "_ld_we"}, {31'b0, cache_we}, 32'd0);
                end else begin
                    chk({tag, "_st_we"}, {31'b0, cache_we}, 32'd1);
                    chk({tag, "_st_isw"}, {31'b0, cache_is_word}, {31'b0, e.is_word});
                    chk({tag, "_st_wd"}, cache_wdata, e.wdata);
                    chk({tag, "_st_meta"},
                        {29'b0, cache_meta_we, cache_set_valid, cache_set_dirty},
                        32'd7);
                end
            end else begin
                lat++;
            end
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    task automatic line_chk(input logic [10:0] i, input logic v,
                            input logic d, input logic [31:0] data,
                            input string tag);
        chk({tag, "_valid"}, {31'b0, c_valid[i]}, {31'b0, v});
        chk({tag, "_dirty"}, {31'b0, c_dirty[i]}, {31'b0, d});
        chk({tag, "_data"}, c_data[i], data);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            c_valid[i] = 1'b0;
            c_dirty[i] = 1'b0;
            c_tag[i]   = 3'd0;
            c_data[i]  = 32'h0;
        end
        c_valid[11'h010] = 1'b1;
        c_data[11'h010]  = 32'hDEADBEEF;
        mem_arr[32'h40]   = 32'hDEADBEEF;
        mem_arr[32'h2040] = 32'h12345678;
        mem_auto    = 1'b1;
        mem_delay   = 3;
        reset       = 1'b1;
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_is_word = 1'b1;
        cpu_addr    = 32'h40;
        cpu_wdata   = 32'h11111111;

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_cache_we", {31'b0, cache_we}, 32'd0);
        chk("rst_meta_we", {31'b0, cache_meta_we}, 32'd0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_cache_addr", cache_addr, 32'h40);
`ifdef CACHE_CTRL_STATS_EN
        chk("rst_stat_hits", stat_hits, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset   = 1'b0;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;

        access(32'h40, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF, 0, "ld_hit");

        exp_mq.push_back('{1'b0, 32'h2040, 32'h0});
        access(32'h2040, 1'b0, 1'b1, 32'h0, 32'h12345678, 5, "ld_clean");
        line_chk(11'h010, 1'b1, 1'b0, 32'h12345678, "ld_clean_line");

        exp_mq.push_back('{1'b0, 32'h40, 32'h0});
        access(32'h40, 1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 5, "st_word");
        line_chk(11'h010, 1'b1, 1'b1, 32'hCAFEF00D, "st_word_line");

        exp_mq.push_back('{1'b1, 32'h40, 32'hCAFEF00D});
        exp_mq.push_back('{1'b0, 32'h2040, 32'h0});
        access(32'h2040, 1'b0, 1'b1, 32'h0, 32'h12345678, 9, "ld_dirty");
        line_chk(11'h010, 1'b1, 1'b0, 32'h12345678, "ld_dirty_line");

        access(32'h2041, 1'b1, 1'b0, 32'h000000AB, 32'h0, 0, "st_byte_hit");
        line_chk(11'h010, 1'b1, 1'b1, 32'h1234AB78, "st_byte_hit_line");
`ifdef CACHE_CTRL_STATS_EN
        chk("stat_hits", stat_hits, 32'd2);
        chk("stat_misses", stat_misses, 32'd3);
        chk("stat_writebacks", stat_writebacks, 32'd1);
`endif

        exp_mq.push_back('{1'b1, 32'h2040, 32'h1234AB78});
        exp_mq.push_back('{1'b0, 32'h40, 32'h0});
        access(32'h41, 1'b1, 1'b0, 32'h000000CD, 32'h0, 9, "st_byte_miss");
        line_chk(11'h010, 1'b1, 1'b1, 32'hCAFECD0D, "st_byte_miss_line");
        chk("mem_wb_2040", mem_arr[32'h2040], 32'h1234AB78);
        chk("mem_queue_empty", exp_mq.size(), 32'd0);

        // mem_ack while idle must not write the cache
        mem_auto = 1'b0;
        @(posedge clk);
        #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h77777777;
        @(negedge clk);
        chk("idle_ack_we", {31'b0, cache_we}, 32'd0);
        chk("idle_ack_ready", {31'b0, cpu_ready}, 32'd0);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;

        // reset during FILL with a simultaneous ack
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h100;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fill_mem_req", {31'b0, mem_req}, 32'd1);
        chk("fill_mem_addr", mem_addr, 32'h100);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        chk("rstfill_cache_we", {31'b0, cache_we}, 32'd0);
        chk("rstfill_meta_we", {31'b0, cache_meta_we}, 32'd0);
        chk("rstfill_mem_req", {31'b0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mem_ack = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("rstfill_idle_req", {31'b0, mem_req}, 32'd0);
        chk("rstfill_no_line", {31'b0, c_valid[11'h040]}, 32'd0);
`ifdef CACHE_CTRL_STATS_EN
        chk("rstfill_stat_misses", stat_misses, 32'd0);
        chk("rstfill_stat_wb", stat_writebacks, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
